// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and slave FSM state encoding shared by the
// test-memory slave and its bench.
package tl_pkg;

  localparam logic [2:0] TL_PUTFULL = 3'd0;
  localparam logic [2:0] TL_PUTPART = 3'd1;
  localparam logic [2:0] TL_GET     = 3'd4;
  localparam logic [2:0] TL_ACK     = 3'd0;
  localparam logic [2:0] TL_ACKDATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_WACK = 2'd2,
    ST_RD   = 2'd3
  } tl_st_e;

endpackage

// File: rtl/tl_mem_ram.sv
// Byte-enabled RAM: one write port, one registered synchronous read port.
// Contents start zeroed.
module tl_mem_ram #(
  parameter int DW        = 128,
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = "",
  localparam int BYTES    = DW / 8,
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [BYTES-1:0] i_be,
  input  logic [DW-1:0]    i_wdata,
  input  logic [IW-1:0]    i_raddr,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < BYTES; b++)
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tl_mem_slv.sv
// TileLink-UL slave memory: Get / PutFull / PutPartial with bursts, byte masks,
// denied responses for bad requests, and one outstanding transaction.
module tl_mem_slv
  import tl_pkg::*;
#(
  parameter int             DW        = 128,
  parameter int             AW        = 32,
  parameter int             DEPTH     = 4096,
  parameter logic [AW-1:0]  BASE      = 32'h8000_0000,
  parameter int             SRC_W     = 3,
  parameter int             MAX_SIZE  = 6,
  parameter                 INIT_FILE = "",
  localparam int            BYTES     = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       tlslv_a_opcode,
  input  logic [2:0]       tlslv_a_param,
  input  logic [7:0]       tlslv_a_size,
  input  logic [SRC_W-1:0] tlslv_a_source,
  input  logic [AW-1:0]    tlslv_a_address,
  input  logic [BYTES-1:0] tlslv_a_mask,
  input  logic [DW-1:0]    tlslv_a_data,
  input  logic             tlslv_a_corrupt,
  input  logic             tlslv_a_valid,
  output logic             tlslv_a_ready,
  output logic [2:0]       tlslv_d_opcode,
  output logic [1:0]       tlslv_d_param,
  output logic [7:0]       tlslv_d_size,
  output logic [SRC_W-1:0] tlslv_d_source,
  output logic [2:0]       tlslv_d_sink,
  output logic             tlslv_d_denied,
  output logic [DW-1:0]    tlslv_d_data,
  output logic             tlslv_d_corrupt,
  output logic             tlslv_d_valid,
  input  logic             tlslv_d_ready
);

  localparam int         LOG2B = $clog2(BYTES);
  localparam int         IW    = $clog2(DEPTH);
  localparam logic [AW:0] RANGE = (AW+1)'(DEPTH * BYTES);

  tl_st_e             r_state;
  logic               r_a_ready;
  logic               r_d_valid;
  logic [2:0]         r_d_opcode;
  logic [7:0]         r_d_size;
  logic [SRC_W-1:0]   r_d_source;
  logic               r_d_denied;
  logic               r_d_corrupt;
  logic [IW-1:0]      r_idx;
  logic [7:0]         r_beat;
  logic [7:0]         r_last;

  logic               w_a_fire, w_d_fire, w_is_put, w_is_get, w_badop;
  logic [AW-1:0]      w_off;
  logic [AW:0]        w_len, w_end;
  logic [LOG2B-1:0]   w_amask;
  logic [7:0]         w_sh, w_last;
  logic               w_oor, w_misal, w_bigsz, w_deny;
  logic [IW-1:0]      w_a_idx, w_waddr, w_raddr;
  logic               w_we;
  logic [DW-1:0]      w_rdata;
  logic               w_unused;

  assign w_a_fire = tlslv_a_valid & r_a_ready;
  assign w_d_fire = r_d_valid & tlslv_d_ready;
  assign w_is_get = tlslv_a_opcode == TL_GET;
  assign w_is_put = tlslv_a_opcode inside {TL_PUTFULL, TL_PUTPART};
  assign w_badop  = ~(w_is_get | w_is_put);
  assign w_unused = ^tlslv_a_param;

  // Range check spans the whole burst, so the beat index can never wrap.
  assign w_off   = tlslv_a_address - BASE;
  assign w_a_idx = w_off[LOG2B +: IW];
  assign w_bigsz = tlslv_a_size > 8'(MAX_SIZE);
  assign w_len   = w_bigsz ? '0 : ((AW+1)'(1) << tlslv_a_size);
  assign w_end   = {1'b0, w_off} + w_len;
  assign w_oor   = (tlslv_a_address < BASE) | (w_end > RANGE);
  assign w_amask = (tlslv_a_size >= 8'(LOG2B)) ? '1
                 : LOG2B'((32'd1 << tlslv_a_size) - 32'd1);
  assign w_misal = |(tlslv_a_address[LOG2B-1:0] & w_amask);
  assign w_deny  = w_bigsz | w_misal | w_oor | w_badop;

  always_comb begin
    w_sh   = tlslv_a_size - 8'(LOG2B);
    w_last = '0;
    if (tlslv_a_size > 8'(LOG2B))
      w_last = (w_sh >= 8'd8) ? 8'hFF : 8'((32'd1 << w_sh) - 32'd1);
  end

  assign w_we    = w_a_fire & ~tlslv_a_corrupt &
                   (((r_state == ST_IDLE) & w_is_put & ~w_deny) |
                    ((r_state == ST_WR) & ~r_d_denied));
  assign w_waddr = (r_state == ST_IDLE) ? w_a_idx : r_idx;
  // Prefetch the next word on a D fire so burst beats stream back to back.
  assign w_raddr = (r_state == ST_IDLE) ? w_a_idx
                 : (w_d_fire & (r_state == ST_RD)) ? r_idx + IW'(1) : r_idx;

  tl_mem_ram #(.DW(DW), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_be   (tlslv_a_mask),
    .i_wdata(tlslv_a_data),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_a_ready   <= 1'b1;
      r_d_valid   <= 1'b0;
      r_d_opcode  <= '0;
      r_d_size    <= '0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_corrupt <= 1'b0;
      r_idx       <= '0;
      r_beat      <= '0;
      r_last      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_a_fire) begin
          r_d_size   <= tlslv_a_size;
          r_d_source <= tlslv_a_source;
          r_d_denied <= w_deny;
          r_last     <= w_last;
          if (w_is_get) begin
            r_state     <= ST_RD;
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b1;
            r_d_opcode  <= TL_ACKDATA;
            r_d_corrupt <= w_deny;
            r_idx       <= w_a_idx;
            r_beat      <= '0;
          end else if (w_badop || w_last == 8'd0) begin
            r_state     <= ST_WACK;
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b1;
            r_d_opcode  <= TL_ACK;
            r_d_corrupt <= 1'b0;
          end else begin
            r_state     <= ST_WR;
            r_d_opcode  <= TL_ACK;
            r_d_corrupt <= 1'b0;
            r_idx       <= w_a_idx + IW'(1);
            r_beat      <= 8'd1;
          end
        end
        ST_WR: if (w_a_fire) begin
          r_idx <= r_idx + IW'(1);
          if (r_beat == r_last) begin
            r_state   <= ST_WACK;
            r_a_ready <= 1'b0;
            r_d_valid <= 1'b1;
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        ST_WACK: if (w_d_fire) begin
          r_state   <= ST_IDLE;
          r_a_ready <= 1'b1;
          r_d_valid <= 1'b0;
        end
        ST_RD: if (w_d_fire) begin
          if (r_beat == r_last) begin
            r_state   <= ST_IDLE;
            r_a_ready <= 1'b1;
            r_d_valid <= 1'b0;
          end else begin
            r_beat <= r_beat + 8'd1;
            r_idx  <= r_idx + IW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tlslv_a_ready   = r_a_ready;
  assign tlslv_d_valid   = r_d_valid;
  assign tlslv_d_opcode  = r_d_opcode;
  assign tlslv_d_param   = 2'd0;
  assign tlslv_d_size    = r_d_size;
  assign tlslv_d_source  = r_d_source;
  assign tlslv_d_sink    = 3'd0;
  assign tlslv_d_denied  = r_d_denied;
  assign tlslv_d_corrupt = r_d_corrupt;
  assign tlslv_d_data    = ((r_state == ST_RD) && !r_d_denied) ? w_rdata : '0;

endmodule
